// File: rtl/inst_ram_loader_pkg.sv
// Shared opcodes, state encoding and widths for the instruction RAM loader.
package inst_ram_loader_pkg;

    localparam logic [7:0]  CMD_SETADDR = 8'hA5;
    localparam logic [7:0]  CMD_WRITE   = 8'h5A;
    localparam logic [7:0]  CMD_READ    = 8'h3C;
    localparam logic [29:0] ADDR_RST    = 30'h0;
    localparam int          IDX_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_CNT,
        GET_DATA,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_SEND
    } state_t;

endpackage

// File: rtl/inst_ram_loader_word_pack.sv
// Little-endian 4-byte assembler with byte index and last-byte flag.
module inst_ram_loader_word_pack
    import inst_ram_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       byte_in,
    output logic [31:0]      word,
    output logic [IDX_W-1:0] idx,
    output logic             done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= 32'h0;
            idx  <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            word[{idx, 3'b000} +: 8] <= byte_in;
            idx                      <= idx + 1'b1;
        end
    end

    assign done = en & ~clr & (&idx);

endmodule

// File: rtl/inst_ram_loader.sv
// Host byte-stream loader: programs instruction RAM port B and reads words back.
module inst_ram_loader
    import inst_ram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        ram_web,
    output logic [29:0] ram_addrb,
    output logic [31:0] ram_dinb,
    input  logic [31:0] ram_doutb,
    output logic        busy,
    output logic        err_cmd
);

    state_t             state, state_n;
    logic [29:0]        addr, addr_n;
    logic [15:0]        cnt, cnt_n;
    logic [31:0]        rdata, rdata_n;
    logic [IDX_W-1:0]   tidx, tidx_n;
    logic               err_n;
    logic               accept;
    logic               pk_clr, pk_en, pk_done;
    logic [31:0]        pk_word;
    logic [IDX_W-1:0]   pk_idx;
    logic [15:0]        cnt_in;

    assign accept = rx_valid & rx_ready;
    assign cnt_in = {rx_data, pk_word[7:0]};
    assign pk_en  = accept & (state != IDLE);
    // Count uses only two bytes, so the index is rewound before data bytes.
    assign pk_clr = (state == IDLE) |
                    ((state == GET_CNT) & accept & pk_idx[0]);

    inst_ram_loader_word_pack u_pack (
        .clk     (clk),
        .rst     (rst),
        .clr     (pk_clr),
        .en      (pk_en),
        .byte_in (rx_data),
        .word    (pk_word),
        .idx     (pk_idx),
        .done    (pk_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= ADDR_RST;
            cnt     <= 16'h0;
            rdata   <= 32'h0;
            tidx    <= '0;
            err_cmd <= 1'b0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            cnt     <= cnt_n;
            rdata   <= rdata_n;
            tidx    <= tidx_n;
            err_cmd <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        cnt_n   = cnt;
        rdata_n = rdata;
        tidx_n  = tidx;
        err_n   = err_cmd;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_SETADDR: state_n = GET_ADDR;
                        CMD_WRITE:   state_n = GET_CNT;
                        CMD_READ:    state_n = RD_REQ;
                        default:     err_n   = 1'b1;
                    endcase
                end
            end
            GET_ADDR: begin
                if (pk_done) begin
                    addr_n  = {rx_data, pk_word[23:2]};
                    state_n = IDLE;
                end
            end
            GET_CNT: begin
                if (accept && pk_idx[0]) begin
                    cnt_n   = cnt_in;
                    state_n = (cnt_in == 16'h0) ? IDLE : GET_DATA;
                end
            end
            GET_DATA: begin
                if (pk_done)
                    state_n = WRITE;
            end
            WRITE: begin
                addr_n  = addr + 30'd1;
                cnt_n   = cnt - 16'd1;
                state_n = (cnt == 16'd1) ? IDLE : GET_DATA;
            end
            RD_REQ: begin
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_n = ram_doutb;
                addr_n  = addr + 30'd1;
                tidx_n  = '0;
                state_n = RD_SEND;
            end
            RD_SEND: begin
                if (tx_ready) begin
                    tidx_n = tidx + 1'b1;
                    if (&tidx)
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_ready  = (state == IDLE) | (state == GET_ADDR) |
                       (state == GET_CNT) | (state == GET_DATA);
    assign tx_valid  = (state == RD_SEND);
    assign tx_data   = tx_valid ? rdata[{tidx, 3'b000} +: 8] : 8'h0;
    assign ram_web   = (state == WRITE);
    assign ram_addrb = addr;
    assign ram_dinb  = pk_word;
    assign busy      = (state != IDLE);

endmodule

// File: doc/inst_ram_loader.md
Name: inst_ram_loader

Overview:
- Byte-stream loader and readback engine that drives the write port (port B) of the instruction RAM.
- Accepts command and data bytes from a host link, for example a UART receiver, over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them through web/addrb/dinb.
- Reads words back through doutb and returns them as a byte stream.
- Holds the CPU off (busy) while a command is in progress.

Parameters:
- CMD_SETADDR, 8'hA5, opcode: next 4 bytes (LE) are the byte address.
- CMD_WRITE, 8'h5A, opcode: next 2 bytes (LE) are word count N, then 4N data bytes.
- CMD_READ, 8'h3C, opcode: read one word at the current address and return 4 bytes (LE).
- ADDR_RST, 30'h0, word-address register value after reset.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- tx_data  out  8  outgoing readback byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte.
- ram_web  out  1  RAM port-B write enable.
- ram_addrb  out  30  RAM port-B word address [31:2].
- ram_dinb  out  32  RAM port-B write data.
- ram_doutb  in  32  RAM port-B read data, registered, valid 1 cycle after ram_addrb.
- busy  out  1  high whenever state != IDLE.
- err_cmd  out  1  sticky: an unknown opcode was received.

Behaviour:
- Reset values: state=IDLE, addr=ADDR_RST, rx_ready=1, tx_valid=0, tx_data=0, ram_web=0, ram_dinb=0, busy=0, err_cmd=0.
- Byte accept = rx_valid & rx_ready. The loader ignores rx_data in every other cycle.
- rx_ready=1 in IDLE, GET_ADDR, GET_CNT and GET_DATA; 0 in all other states.
- ram_addrb = addr register, combinational from the register.
- ram_dinb = word assembly register.
- States:
  - IDLE, on accept:
    - CMD_SETADDR -> GET_ADDR (byte idx=0).
    - CMD_WRITE -> GET_CNT (idx=0).
    - CMD_READ -> RD_REQ.
    - any other byte -> err_cmd<=1, stay IDLE.
  - GET_ADDR: shift in 4 bytes LSB first. On the 4th accept, addr <= assembled[31:2]; bits [1:0] are discarded. -> IDLE.
  - GET_CNT: 2 bytes LSB first into cnt[15:0]. On the 2nd accept: N==0 -> IDLE; else -> GET_DATA (idx=0).
  - GET_DATA: byte k goes into word[8k+7:8k]. After the 4th accept -> WRITE.
  - WRITE (exactly one cycle): ram_web=1, ram_addrb=addr, ram_dinb=word. Next cycle: addr<=addr+1, cnt<=cnt-1. If cnt==1 -> IDLE, else -> GET_DATA.
  - RD_REQ (1 cycle): ram_addrb=addr. -> RD_WAIT.
  - RD_WAIT (1 cycle): capture rdata<=ram_doutb, then addr<=addr+1. -> RD_SEND (idx=0).
  - RD_SEND: tx_valid=1 and tx_data=rdata[8idx+7:8idx]. idx advances only on tx_valid&tx_ready. tx_data and tx_valid stay stable while stalled. After byte 3 is taken -> IDLE, tx_valid=0.
- Timing:
  - Minimum write throughput: one word per 5 cycles.
  - Read latency, CMD_READ accept to first tx_valid: 3 cycles.
- Arithmetic:
  - addr is 30 bits and wraps 30'h3FFF_FFFF -> 0 with no flag.
  - Out-of-range addresses are passed through; the RAM ignores them.
- ram_web is never asserted outside WRITE.
- Only byte accepts advance the protocol; rx_valid gaps mid-word are legal and hold state.
- Reset mid-operation: the partial word/count is discarded, no write is issued, and the address returns to ADDR_RST.
- err_cmd is cleared only by rst.

Decomposition:
- Shared package: opcode constants, state enum (IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, RD_REQ, RD_WAIT, RD_SEND), byte-index width.
- One natural sub-module, loader_word_pack: a 4-byte LE shift/assemble register with index counter and done flag. It is reused for the address and data paths.
- Readback byte selection stays inline.

Test Plan:
- Write A5 10 00 00 00, then 5A 02 00 93 02 00 00 13 03 00 00 -> two single-cycle ram_web pulses:
  - ram_addrb=4, ram_dinb=32'h00000293;
  - ram_addrb=5, ram_dinb=32'h00000313;
  - busy falls after the second pulse.
- Readback: after the writes above, A5 10 00 00 00 then 3C -> tx bytes 93 02 00 00. With tx_ready held low 3 cycles, tx_data stays 8'h93. Address becomes 5.
- Zero count: A5 00 00 00 00, 5A 00 00 -> no ram_web, state returns to IDLE, next byte 3C is accepted as a command.
- Wrap: A5 FC FF FF FF, 5A 02 00 plus 8 data bytes -> writes at ram_addrb=30'h3FFFFFFF then 30'h0.
- Unknown opcode FF -> err_cmd=1 and stays 1, no write. A following A5 sequence is still decoded correctly.
- Reset mid-write: assert rst after 2 of 4 data bytes -> outputs at reset values, no ram_web. A new full write sequence succeeds at address 0.
